cb_rr_param: RTL and testbench

- Parametrised successor of the fixed 5x5 router crossbar.
- Size is generic: NPORT inputs and outputs, generic data width and virtual-channel (VC) field width.
- Each output has a registered round-robin arbiter. The arbiter holds its grant for a whole packet, from the first granted flit until the tail flit.
- Sits between the input VC buffers/route computation and the output links of the NoC router.

---
 rtl/cb_rr_param_if.sv | 37 +++
 rtl/cb_rr_param.sv | 193 +++++++++++++++++++
 tb/tb_cb_rr_param.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cb_rr_param_if.sv
// Bundle of crossbar-side signals for cb_rr_param.
// The master side is the input VC buffers / route computation together with
// the output-link consumer. The slave side is the crossbar itself.
interface cb_rr_param_if #(
   parameter int NPORT = 5,
   parameter int DATAW = 32,
   parameter int VCHW  = 2,
   parameter int PORTW = $clog2(NPORT)
);
   // Upstream flit presentation, one slice per input port
   logic [NPORT*DATAW-1:0] idata;
   logic [NPORT-1:0]       ivalid;
   logic [NPORT*VCHW-1:0]  ivch;
   logic [NPORT-1:0]       itail;

   // Routing request: each input names one output and raises req
   logic [NPORT*PORTW-1:0] port;
   logic [NPORT-1:0]       req;

   // Grant matrix, bit [i*NPORT+o] = output o owned by input i
   logic [NPORT*NPORT-1:0] grt;

   // Output links, one slice per output port
   logic [NPORT*DATAW-1:0] odata;
   logic [NPORT-1:0]       ovalid;
   logic [NPORT*VCHW-1:0]  ovch;

   modport master (
      output idata, ivalid, ivch, itail, port, req,
      input  grt, odata, ovalid, ovch
   );

   modport slave (
      input  idata, ivalid, ivch, itail, port, req,
      output grt, odata, ovalid, ovch
   );
endinterface

// File: rtl/cb_rr_param.sv
// cb_rr_param: NPORT x NPORT packet-switched crossbar for the NoC router.
// Each output owns a round-robin arbiter that locks onto one input for a
// whole packet (first granted flit up to and including the tail flit), then
// leaves one idle cycle before the next grant. The pointer moves to the
// input after the last owner, so no requester waits more than NPORT-1
// packets.
//
// Build option: define CB_OUTREG_EN to register odata/ovalid/ovch (one
// cycle of datapath latency). Without it the outputs are combinational
// from the owning input. Arbiter timing is the same in both builds.
module cb_rr_param #(
   parameter int NPORT = 5,
   parameter int DATAW = 32,
   parameter int VCHW  = 2,
   parameter int PORTW = $clog2(NPORT)
) (
   input logic          clk,
   input logic          rst_,
   cb_rr_param_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Per-output arbiter state
   arb_state_e       state_q [NPORT];
   arb_state_e       state_d [NPORT];
   logic [PORTW-1:0] owner_q [NPORT];
   logic [PORTW-1:0] owner_d [NPORT];
   logic [PORTW-1:0] ptr_q   [NPORT];
   logic [PORTW-1:0] ptr_d   [NPORT];

   // Round-robin pick for each output while it is idle
   logic             sel_vld [NPORT];
   logic [PORTW-1:0] sel_idx [NPORT];

   // Owner-selected flit for each output, before optional output register
   logic [NPORT*NPORT-1:0] grt_w;
   logic [NPORT-1:0]       fwd_valid;
   logic [NPORT*DATAW-1:0] fwd_data;
   logic [NPORT*VCHW-1:0]  fwd_vch;

   // Successor of an input index, wrapping at NPORT
   function automatic logic [PORTW-1:0] next_port(input logic [PORTW-1:0] idx);
      logic [PORTW-1:0] nxt;
      if (idx == PORTW'(NPORT - 1)) begin
         nxt = '0;
      end else begin
         nxt = idx + PORTW'(1);
      end
      return nxt;
   endfunction

   // Find the first requesting input at or after each output's pointer
   always_comb begin : rr_select
      logic [NPORT-1:0] cand;
      logic [PORTW:0]   slot;
      logic             found;
      logic [PORTW-1:0] pick;
      // NOTE: every variable gets a default before any conditional write, so
      // no path leaves a value held over and no latch is inferred.
      cand  = '0;
      slot  = '0;
      found = 1'b0;
      pick  = '0;
      for (int o = 0; o < NPORT; o++) begin
         // Inputs routed to a port >= NPORT never match any o here
         for (int i = 0; i < NPORT; i++) begin
            cand[i] = bus.req[i] && (bus.port[i*PORTW +: PORTW] == PORTW'(o));
         end
         found = 1'b0;
         pick  = '0;
         for (int k = 0; k < NPORT; k++) begin
            // ptr + k stays below 2*NPORT, so one subtraction wraps it
            slot = {1'b0, ptr_q[o]} + (PORTW+1)'(k);
            if (slot >= (PORTW+1)'(NPORT)) begin
               slot = slot - (PORTW+1)'(NPORT);
            end
            if (!found && cand[slot[PORTW-1:0]]) begin
               found = 1'b1;
               pick  = slot[PORTW-1:0];
            end
         end
         sel_vld[o] = found;
         sel_idx[o] = pick;
      end
   end

   // Arbiter next state: grant from IDLE, release on tail or abort from BUSY
   always_comb begin : arb_next
      for (int o = 0; o < NPORT; o++) begin
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
         ptr_d[o]   = ptr_q[o];
         case (state_q[o])
            IDLE: begin
               if (sel_vld[o]) begin
                  state_d[o] = BUSY;
                  owner_d[o] = sel_idx[o];
               end
            end
            BUSY: begin
               // Owner is locked: its port/req fields are not re-routed,
               // only req is watched for an abort.
               if ((bus.ivalid[owner_q[o]] && bus.itail[owner_q[o]]) ||
                   !bus.req[owner_q[o]]) begin
                  state_d[o] = IDLE;
                  ptr_d[o]   = next_port(owner_q[o]);
               end
            end
            default: begin
               state_d[o] = IDLE;
            end
         endcase
      end
   end

   // Arbiter state registers; reset drops every grant asynchronously
   always_ff @(posedge clk or negedge rst_) begin : arb_regs
      // NOTE: the per-output arrays are small control registers that steer
      // the grants, so every entry is reset rather than left uninitialised.
      if (!rst_) begin
         for (int o = 0; o < NPORT; o++) begin
            state_q[o] <= IDLE;
            owner_q[o] <= '0;
            ptr_q[o]   <= '0;
         end
      end else begin
         // NOTE: non-blocking updates so all outputs see the same
         // pre-edge state regardless of loop order.
         for (int o = 0; o < NPORT; o++) begin
            state_q[o] <= state_d[o];
            owner_q[o] <= owner_d[o];
            ptr_q[o]   <= ptr_d[o];
         end
      end
   end

   // Decode grants and select the owner's flit for each output
   always_comb begin : grant_mux
      grt_w     = '0;
      fwd_valid = '0;
      fwd_data  = '0;
      fwd_vch   = '0;
      for (int o = 0; o < NPORT; o++) begin
         for (int i = 0; i < NPORT; i++) begin
            if (state_q[o] == BUSY && owner_q[o] == PORTW'(i)) begin
               grt_w[i*NPORT + o]          = 1'b1;
               fwd_valid[o]                = bus.ivalid[i];
               fwd_data[o*DATAW +: DATAW]  = bus.idata[i*DATAW +: DATAW];
               fwd_vch[o*VCHW +: VCHW]     = bus.ivch[i*VCHW +: VCHW];
            end
         end
      end
   end

   assign bus.grt = grt_w;

`ifdef CB_OUTREG_EN
   logic [NPORT*DATAW-1:0] odata_q;
   logic [NPORT-1:0]       ovalid_q;
   logic [NPORT*VCHW-1:0]  ovch_q;

   // Output register: valid pulses per flit, data/VC hold between flits
   always_ff @(posedge clk or negedge rst_) begin : out_regs
      if (!rst_) begin
         odata_q  <= '0;
         ovalid_q <= '0;
         ovch_q   <= '0;
      end else begin
         ovalid_q <= fwd_valid;
         for (int o = 0; o < NPORT; o++) begin
            if (fwd_valid[o]) begin
               odata_q[o*DATAW +: DATAW] <= fwd_data[o*DATAW +: DATAW];
               ovch_q[o*VCHW +: VCHW]    <= fwd_vch[o*VCHW +: VCHW];
            end
         end
      end
   end

   assign bus.odata  = odata_q;
   assign bus.ovalid = ovalid_q;
   assign bus.ovch   = ovch_q;
`else
   // Zero-latency path: data/VC are zero whenever the output is idle
   assign bus.odata  = fwd_data;
   assign bus.ovalid = fwd_valid;
   assign bus.ovch   = fwd_vch;
`endif

endmodule

// File: tb/tb_cb_rr_param.sv
// Directed bench for cb_rr_param. Flits are pushed to a per-output
// expected queue when driven and popped when the output shows them, so the
// same bench covers both the combinational and registered output builds.
module tb_cb_rr_param;
   localparam int NPORT = 5;
   localparam int DATAW = 32;
   localparam int VCHW  = 2;
   localparam int PORTW = $clog2(NPORT);
   localparam int GW    = NPORT * NPORT;

   typedef struct packed {
      logic [DATAW-1:0] d;
      logic [VCHW-1:0]  v;
   } flit_t;

   logic clk;
   logic rst_;
   int   errors = 0;
   int   checks = 0;

   flit_t sbq [NPORT][$];

   cb_rr_param_if #(.NPORT(NPORT), .DATAW(DATAW), .VCHW(VCHW), .PORTW(PORTW)) bus ();

   cb_rr_param #(.NPORT(NPORT), .DATAW(DATAW), .VCHW(VCHW), .PORTW(PORTW)) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [GW-1:0] gb(input int i, input int o);
      logic [GW-1:0] g;
      g = '0;
      g[i*NPORT + o] = 1'b1;
      return g;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input int p, input logic r);
      bus.req[i] = r;
      bus.port[i*PORTW +: PORTW] = PORTW'(p);
   endtask

   task automatic send(input int i, input logic [DATAW-1:0] d, input logic [VCHW-1:0] v,
                       input logic tail, input int o);
      flit_t f;
      bus.ivalid[i] = 1'b1;
      bus.itail[i]  = tail;
      bus.idata[i*DATAW +: DATAW] = d;
      bus.ivch[i*VCHW +: VCHW]    = v;
      f.d = d;
      f.v = v;
      sbq[o].push_back(f);
   endtask

   task automatic idle_in(input int i);
      bus.ivalid[i] = 1'b0;
      bus.itail[i]  = 1'b0;
   endtask

   // Output monitor: every valid flit must match the oldest expected one
   always @(negedge clk) begin : mon
      flit_t f;
      for (int o = 0; o < NPORT; o++) begin
         if (bus.ovalid[o] === 1'b1) begin
            if (sbq[o].size() == 0) begin
               check($sformatf("spurious_ovalid_o%0d", o), 64'(bus.ovalid[o]), 64'd0);
            end else begin
               f = sbq[o].pop_front();
               check($sformatf("odata_o%0d", o), 64'(bus.odata[o*DATAW +: DATAW]), 64'(f.d));
               check($sformatf("ovch_o%0d", o), 64'(bus.ovch[o*VCHW +: VCHW]), 64'(f.v));
            end
         end
      end
   end

   initial begin
      rst_       = 1'b0;
      bus.idata  = '0;
      bus.ivalid = '0;
      bus.ivch   = '0;
      bus.itail  = '0;
      bus.port   = '0;
      bus.req    = '0;

      // Reset release with no requests: everything quiet for 10 cycles
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst_ = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("rst_grt", 64'(bus.grt), 64'd0);
         check("rst_ovalid", 64'(bus.ovalid), 64'd0);
      end
      check("rst_odata", 64'(bus.odata[3*DATAW +: DATAW]), 64'd0);
      check("rst_ovch", 64'(bus.ovch), 64'd0);

      // Input 2 -> port 3, 4-flit packet 0xA0..0xA3 on VC 1
      tick(); set_req(2, 3, 1'b1);
      @(negedge clk); check("t2_arb_latency", 64'(bus.grt), 64'd0);
      for (int k = 0; k < 4; k++) begin
         tick(); send(2, DATAW'(32'hA0 + k), 2'd1, (k == 3), 3);
         @(negedge clk); check($sformatf("t2_grt_c%0d", k + 1), 64'(bus.grt), 64'(gb(2, 3)));
      end
      tick(); idle_in(2); set_req(2, 3, 1'b0);
      @(negedge clk); check("t2_grt_cleared", 64'(bus.grt), 64'd0);

      // Inputs 0, 1, 4 -> port 0, single-flit packets, continuous req
      tick(); set_req(0, 0, 1'b1); set_req(1, 0, 1'b1); set_req(4, 0, 1'b1);
      @(negedge clk); check("t3_arb_latency", 64'(bus.grt), 64'd0);
      tick(); send(0, 32'hB0, 2'd2, 1'b1, 0);
      @(negedge clk); check("t3_grant_in0", 64'(bus.grt), 64'(gb(0, 0)));
      tick(); idle_in(0);
      @(negedge clk); check("t3_gap1", 64'(bus.grt), 64'd0);
      tick(); send(1, 32'hB1, 2'd2, 1'b1, 0);
      // Non-owner flit on input 4 must not reach output 0
      bus.ivalid[4] = 1'b1;
      bus.idata[4*DATAW +: DATAW] = 32'hDEAD;
      @(negedge clk); check("t3_grant_in1", 64'(bus.grt), 64'(gb(1, 0)));
      tick(); idle_in(1); idle_in(4);
      @(negedge clk); check("t3_gap2", 64'(bus.grt), 64'd0);
      tick(); send(4, 32'hB4, 2'd2, 1'b1, 0);
      @(negedge clk); check("t3_grant_in4", 64'(bus.grt), 64'(gb(4, 0)));
      tick(); idle_in(4);
      @(negedge clk); check("t3_gap3", 64'(bus.grt), 64'd0);
      tick(); send(0, 32'hB5, 2'd2, 1'b1, 0);
      @(negedge clk); check("t3_grant_in0_again", 64'(bus.grt), 64'(gb(0, 0)));
      tick(); idle_in(0); set_req(0, 0, 1'b0); set_req(1, 0, 1'b0); set_req(4, 0, 1'b0);
      @(negedge clk); check("t3_done", 64'(bus.grt), 64'd0);

      // Input 1 -> port 2, aborts mid-packet; pointer then favours input 2
      tick(); set_req(1, 2, 1'b1);
      @(negedge clk); check("t4_arb_latency", 64'(bus.grt), 64'd0);
      tick(); send(1, 32'hC0, 2'd3, 1'b0, 2);
      @(negedge clk); check("t4_grant_c1", 64'(bus.grt), 64'(gb(1, 2)));
      tick(); send(1, 32'hC1, 2'd3, 1'b0, 2);
      @(negedge clk); check("t4_grant_c2", 64'(bus.grt), 64'(gb(1, 2)));
      tick(); idle_in(1); set_req(1, 2, 1'b0);
      @(negedge clk); check("t4_abort_hold", 64'(bus.grt), 64'(gb(1, 2)));
      tick(); set_req(1, 2, 1'b1); set_req(2, 2, 1'b1);
      @(negedge clk); check("t4_released", 64'(bus.grt), 64'd0);
      tick();
      @(negedge clk); check("t4_ptr_is_2", 64'(bus.grt), 64'(gb(2, 2)));
      tick(); set_req(1, 2, 1'b0); set_req(2, 2, 1'b0);
      @(negedge clk); check("t4_abort2_hold", 64'(bus.grt), 64'(gb(2, 2)));
      tick();
      @(negedge clk); check("t4_done", 64'(bus.grt), 64'd0);

      // Input 0 -> port 4 and input 3 -> port 1 concurrently
      tick(); set_req(0, 4, 1'b1); set_req(3, 1, 1'b1);
      @(negedge clk); check("t5_arb_latency", 64'(bus.grt), 64'd0);
      tick(); send(0, 32'hD0, 2'd0, 1'b1, 4); send(3, 32'hE0, 2'd1, 1'b0, 1);
      @(negedge clk); check("t5_both", 64'(bus.grt), 64'(gb(0, 4) | gb(3, 1)));
      tick(); idle_in(0); set_req(0, 4, 1'b0); send(3, 32'hE1, 2'd1, 1'b1, 1);
      @(negedge clk); check("t5_in3_only", 64'(bus.grt), 64'(gb(3, 1)));
      tick(); idle_in(3); set_req(3, 1, 1'b0);
      @(negedge clk); check("t5_done", 64'(bus.grt), 64'd0);
      tick();

      // Reset while port 0 is busy with input 1
      tick(); set_req(1, 0, 1'b1);
      @(negedge clk); check("t6_arb_latency", 64'(bus.grt), 64'd0);
      tick(); send(1, 32'hF0, 2'd2, 1'b0, 0);
      @(negedge clk); check("t6_grant_in1", 64'(bus.grt), 64'(gb(1, 0)));
      tick(); send(1, 32'hF1, 2'd2, 1'b0, 0);
      #2;
      check("t6_pre_reset_ovalid", 64'(bus.ovalid[0]), 64'd1);
      rst_ = 1'b0;
      #1;
      check("t6_async_grt", 64'(bus.grt), 64'd0);
      check("t6_async_ovalid", 64'(bus.ovalid), 64'd0);
      for (int o = 0; o < NPORT; o++) sbq[o].delete();
      idle_in(1); set_req(1, 0, 1'b0);
      @(negedge clk);
      #1 rst_ = 1'b1;
      // Pointers restart at 0: port 3 must pick input 1 over input 3
      tick(); set_req(4, 0, 1'b1); set_req(1, 3, 1'b1); set_req(3, 3, 1'b1);
      @(negedge clk); check("t6_arb_latency2", 64'(bus.grt), 64'd0);
      tick();
      @(negedge clk); check("t6_ptr_reset", 64'(bus.grt), 64'(gb(4, 0) | gb(1, 3)));
      tick(); set_req(4, 0, 1'b0); set_req(1, 3, 1'b0); set_req(3, 3, 1'b0);
      @(negedge clk); check("t6_abort_hold", 64'(bus.grt), 64'(gb(4, 0) | gb(1, 3)));
      tick();
      @(negedge clk); check("t6_done", 64'(bus.grt), 64'd0);
      tick();
      @(negedge clk);

      // Every flit sent must have appeared on its output
      for (int o = 0; o < NPORT; o++) begin
         check($sformatf("drain_o%0d", o), 64'(sbq[o].size()), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
